// File: rtl/io_cfg_loader_pkg.sv
// Shared types and sizing for the IO-row configuration loader.
package io_cfg_loader_pkg;

  localparam int unsigned IO_BITS_PER_TILE = 2;
  localparam int unsigned IO_TILES         = 8;
  localparam int unsigned CFG_WORD_W       = 16;
  localparam int unsigned IDX_W            = 4;
  localparam int unsigned ADDR_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Bit index -> decoder address: address[0] is the bit inside the tile,
  // address[1:3] is the tile number with address[1] as its MSB.
  function automatic logic [0:ADDR_W-1] bit_address(input logic [IDX_W-1:0] idx);
    bit_address = {idx[0], idx[3:1]};
  endfunction

endpackage

// File: rtl/io_cfg_strobe_timer.sv
// Measures the width of the write strobe; expired_c marks its last cycle.
module io_cfg_strobe_timer #(
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic prog_clk,
  input  logic prog_reset_n,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned     CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STROBE_CYC - 1);

  logic [CNT_W-1:0] count;

  assign expired_c = run && (count == LAST);

  // Count strobe cycles; restart whenever the strobe is not running or ends.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n || !run || expired_c) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/io_cfg_loader.sv
// Serialises a 16-bit IO-row configuration word into per-bit decoder writes.
module io_cfg_loader
  import io_cfg_loader_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  cfg_valid,
  input  logic [CFG_WORD_W-1:0] cfg_data,
  output logic                  cfg_ready,
  output logic                  enable,
  output logic [0:ADDR_W-1]     address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  cfg_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IO_TILES * IO_BITS_PER_TILE - 1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [CFG_WORD_W-1:0] shadow;
  logic                  strobe_expired_c;

  assign idx_next = idx + 1'b1;

  io_cfg_strobe_timer #(
    .STROBE_CYC (STROBE_CYC)
  ) u_strobe_timer (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .run          (state == STROBE),
    .expired_c    (strobe_expired_c)
  );

  // Loader FSM; every output is set for the cycle the next state occupies.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      cfg_ready <= 1'b1;
      enable    <= 1'b0;
      address   <= '0;
      data_in   <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            state     <= SETUP;
            shadow    <= cfg_data;
            idx       <= '0;
            address   <= bit_address('0);
            data_in   <= cfg_data[0];
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          state  <= STROBE;
          enable <= 1'b1;
        end
        STROBE: begin
          if (strobe_expired_c) begin
            state  <= HOLD;
            enable <= 1'b0;
          end
        end
        HOLD: begin
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            address   <= '0;
            data_in   <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b1;
          end else begin
            state   <= SETUP;
            idx     <= idx_next;
            address <= bit_address(idx_next);
            data_in <= shadow[idx_next];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
